// File: rtl/param_cpu_if.sv
// Bus bundle for param_cpu: program-load port, run control, status flags and
// the valid/ready result port. The master side drives the program and control
// inputs and consumes results. The slave side is the CPU.
interface param_cpu_if #(
    parameter int DATA_W     = 4,
    parameter int IMEM_DEPTH = 16
);
    localparam int PC_W    = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int INSTR_W = 4 + DATA_W;

    logic               prog_we;
    logic [PC_W-1:0]    prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic               start;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               halt;

    modport master (
        output prog_we, prog_addr, prog_data, start, out_ready,
        input  out_data, out_valid, busy, halt
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, start, out_ready,
        output out_data, out_valid, busy, halt
    );
endinterface

// File: rtl/param_cpu.sv
// param_cpu: parametrised two-register accumulator CPU.
// The program is loaded through the bus while the CPU is not busy. Each instruction
// takes a FETCH cycle and an EXEC cycle. OUT parks the core in WAIT_OUT until the
// sink takes the value. HLT parks it until the next start.
module param_cpu #(
    parameter int DATA_W     = 4,
    parameter int IMEM_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    param_cpu_if.slave  bus
);
    localparam int PC_W    = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int INSTR_W = 4 + DATA_W;

    localparam logic [PC_W-1:0] LAST_PC   = PC_W'(IMEM_DEPTH - 1);
    localparam logic [PC_W:0]   DEPTH_PC  = (PC_W + 1)'(IMEM_DEPTH);
    localparam logic [DATA_W:0] DEPTH_FLD = (DATA_W + 1)'(IMEM_DEPTH);

    localparam logic [3:0] OP_LDI0 = 4'b0000;
    localparam logic [3:0] OP_LDI1 = 4'b0001;
    localparam logic [3:0] OP_ALU  = 4'b0010;
    localparam logic [3:0] OP_MOV  = 4'b0011;
    localparam logic [3:0] OP_JMP  = 4'b0100;
    localparam logic [3:0] OP_JZ   = 4'b0101;
    localparam logic [3:0] OP_JC   = 4'b0110;
    localparam logic [3:0] OP_OUT  = 4'b0111;
    localparam logic [3:0] OP_HLT  = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT_OUT,
        S_HALT
    } state_t;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [DATA_W-1:0]  r_r0;
    logic [DATA_W-1:0]  r_r1;
    logic               r_c;
    logic               r_z;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_halt;
    logic [INSTR_W-1:0] r_imem [IMEM_DEPTH];

    logic [3:0]         w_op;
    logic [DATA_W-1:0]  w_fld;
    logic [PC_W-1:0]    w_pc_inc;
    logic [PC_W-1:0]    w_jmp_tgt;
    logic [DATA_W:0]    w_alu;
    logic               w_wr_ok;

    // ALU result with the carry/borrow flag in the top bit. Results wrap modulo 2**DATA_W.
    function automatic logic [DATA_W:0] alu_f(
        input logic [2:0]        fn,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W:0] r;
        case (fn)
            3'b000:  r = {1'b0, a} + {1'b0, b};
            3'b001:  r = {(a < b), a - b};
            3'b010:  r = {1'b0, a & b};
            3'b011:  r = {1'b0, a | b};
            3'b100:  r = {1'b0, a ^ b};
            3'b101:  r = {a[DATA_W-1], a << 1};
            3'b110:  r = {a[0], a >> 1};
            default: r = {1'b0, ~a};
        endcase
        return r;
    endfunction

    assign w_op      = r_instr[INSTR_W-1 -: 4];
    assign w_fld     = r_instr[DATA_W-1:0];
    // The increment wraps explicitly so that depths which are not a power of two also work.
    assign w_pc_inc  = (r_pc == LAST_PC) ? '0 : r_pc + PC_W'(1);
    // A jump target outside the program memory restarts the program from 0.
    assign w_jmp_tgt = ({1'b0, w_fld} >= DEPTH_FLD) ? '0 : w_fld[PC_W-1:0];
    assign w_alu     = alu_f(w_fld[2:0], r_r0, r_r1);
    assign w_wr_ok   = bus.prog_we && !r_busy && ({1'b0, bus.prog_addr} < DEPTH_PC);

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.halt      = r_halt;

    // Program memory write port. Memory contents are deliberately kept across reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_imem[bus.prog_addr] <= bus.prog_data;
        end
    end

    // Control FSM together with the datapath registers and the registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_instr     <= '0;
            r_r0        <= '0;
            r_r1        <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_halt      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (bus.start) begin
                        r_state <= S_FETCH;
                        r_pc    <= '0;
                        r_busy  <= 1'b1;
                        r_halt  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    r_instr <= r_imem[r_pc];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_state <= S_FETCH;
                    r_pc    <= w_pc_inc;
                    case (w_op)
                        OP_LDI0: r_r0 <= w_fld;
                        OP_LDI1: r_r1 <= w_fld;
                        OP_MOV:  r_r1 <= r_r0;
                        OP_ALU: begin
                            r_r0 <= w_alu[DATA_W-1:0];
                            r_c  <= w_alu[DATA_W];
                            r_z  <= (w_alu[DATA_W-1:0] == '0);
                        end
                        OP_JMP: r_pc <= w_jmp_tgt;
                        OP_JZ: begin
                            if (r_z) r_pc <= w_jmp_tgt;
                        end
                        OP_JC: begin
                            if (r_c) r_pc <= w_jmp_tgt;
                        end
                        OP_OUT: begin
                            // pc advances only once the sink has taken the value.
                            r_pc        <= r_pc;
                            r_out_data  <= r_r0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_WAIT_OUT;
                        end
                        OP_HLT: begin
                            r_pc    <= r_pc;
                            r_halt  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_HALT;
                        end
                        default: ;
                    endcase
                end
                S_WAIT_OUT: begin
                    if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_pc        <= w_pc_inc;
                        r_state     <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
